sc_regshift_serializer: RTL
===========================

// Module: sc_regshift_serializer
// PURPOSE
//   Parallel-in/serial-out transmit register: the unloading end of a parallel general-purpose register.
//   Captures a DATAWIDTH word on an active-low load strobe, then shifts it out MSB-first, one bit per shift tick.
//   Raises busy for the whole transfer and pulses done for one cycle when the transfer ends.
//   Sits between a loadable data register and a serial link or display driver.
// PARAMETERS
//   RegSHIFT_DATAWIDTH  4  word width in bits (>=2)
//   RegSHIFT_CNTWIDTH   2  bit-counter width; must be >= clog2(RegSHIFT_DATAWIDTH)
// PORTS
//   SC_RegSHIFT_CLOCK_50        in   1   system clock, all logic on rising edge
//   SC_RegSHIFT_RESET_InHigh    in   1   reset, synchronous, active-high
//   SC_RegSHIFT_load_InLow      in   1   load strobe, active-low; sampled only in IDLE
//   SC_RegSHIFT_data_InBUS      in   DW  parallel word to transmit
//   SC_RegSHIFT_shift_InHigh    in   1   shift tick/enable, active-high; sampled only in SHIFT
//   SC_RegSHIFT_serial_Out      out  1   serial data, MSB first
//   SC_RegSHIFT_busy_Out        out  1   1 while a transfer is in progress (SHIFT or DONE)
//   SC_RegSHIFT_done_Out        out  1   1-cycle pulse, transfer complete
//   SC_RegSHIFT_data_OutBUS     out  DW  current shift-register contents (debug/observe)
// BEHAVIOUR
//   Reset: synchronous, active-high. On a rising edge with RESET_InHigh=1:
//     state=IDLE, shift reg=0, counter=0. All outputs are 0 after that edge.
//     Reset has priority over every other input, including in the middle of a transfer.
//   FSM states: IDLE -> SHIFT -> DONE -> IDLE. State, shift register and counter are registered.
//   IDLE:
//     load_InLow=0 at an edge: reg<=data_InBUS, cnt<=DW-1, state<=SHIFT.
//     Otherwise the registers hold their values.
//   SHIFT:
//     shift_InHigh=1 at an edge: reg<={reg[DW-2:0],1'b0}.
//       If cnt==0: state<=DONE. Else: cnt<=cnt-1.
//     shift_InHigh=0: hold (the tick stalls the transfer).
//     load_InLow is ignored; there is no abort or restart.
//   DONE:
//     Lasts exactly 1 cycle, then state<=IDLE unconditionally.
//     load_InLow is ignored in DONE. A new load is accepted earliest in the first IDLE cycle.
//   Outputs (decoded combinationally from registered state; no input-to-output combinational path):
//     serial_Out = (state==SHIFT) ? reg[DW-1] : 0  (line idles low)
//     busy_Out   = (state!=IDLE)
//     done_Out   = (state==DONE)
//     data_OutBUS = reg
//   Latency:
//     The MSB is on serial_Out in the first cycle after the load edge.
//     With shift_InHigh held at 1, bit k (MSB=DW-1) is valid during cycle DW-k after the load.
//     done_Out is high in cycle DW+1 after the load. Minimum load-to-load spacing is DW+2 cycles.
//   Counter: unsigned; it never wraps, because SHIFT leaves at cnt==0 before a decrement could underflow.
//   Simultaneous load and shift in IDLE: only the load acts; shift is don't-care.
// STRUCTURE
//   Shared package (sc_regshift_pkg): state encoding localparams
//     ST_IDLE=2'b00, ST_SHIFT=2'b01, ST_DONE=2'b10; 2'b11 decodes to IDLE (safe recovery).
//   One file, three sections: combinational next-state/next-data logic, a sequential register
//     block, and combinational output decode.
//   The bit counter is internal. It is optionally a sub-module sc_regshift_bitcounter
//     (load/decrement/zero flag).
// TESTING (DW=4)
//   1 Reset: assert RESET for 2 cycles with load_InLow=0 -> all outputs 0, state IDLE; load ignored while reset is held.
//   2 Basic: load 4'b1011, shift=1 constantly -> serial 1,0,1,1 on cycles 1..4;
//     busy=1 on cycles 1..5; done=1 only on cycle 5; IDLE on cycle 6.
//   3 Stall: load 4'b1100, toggle shift 1,0,0,1,1,0,1 -> each bit holds while shift=0;
//     done asserts 1 cycle after the 4th tick.
//   4 Load ignored: load 4'b1001, then pulse load_InLow=0 with data 4'b0110 during SHIFT and DONE
//     -> serial stays 1,0,0,1; next IDLE load of 4'b0110 transmits 0,1,1,0.
//   5 Mid-transfer reset: load 4'b1111, reset after 2 shifts -> next cycle serial=0, busy=0,
//     done never pulses, data_OutBUS=0.
//   6 Back-to-back: hold load_InLow=0 throughout with 4'b1010 -> a new transfer starts every 6 cycles
//     (DW+2); serial pattern repeats exactly.

Source files
------------

// File: rtl/sc_regshift_pkg.sv
// -----------------------------------------------------------------------------
// sc_regshift_pkg
//   Shared definitions for the parallel-in/serial-out transmit register.
//   Holds the FSM state encoding used by sc_regshift_serializer.
//   The encoding 2'b11 is never entered. If it ever appears, it is decoded
//   as IDLE and the FSM returns to ST_IDLE on the next edge.
// -----------------------------------------------------------------------------
package sc_regshift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/sc_regshift_bitcounter.sv
// -----------------------------------------------------------------------------
// sc_regshift_bitcounter
//   Down-counter that tracks how many bits are left to transmit.
//   It can be loaded, decremented and reset, and it flags when it reaches zero.
//   The parent decrements only while the count is non-zero, so the counter
//   never wraps.
// Ports
//   i_clk      rising-edge clock
//   i_rst      synchronous active-high reset (count <= 0)
//   i_load     load i_load_val (has priority over i_dec)
//   i_load_val value to load
//   i_dec      decrement by one
//   o_zero     1 when the registered count is 0
// -----------------------------------------------------------------------------
module sc_regshift_bitcounter #(
    parameter int CNTWIDTH = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_load,
    input  logic [CNTWIDTH-1:0] i_load_val,
    input  logic                i_dec,
    output logic                o_zero
);

    logic [CNTWIDTH-1:0] r_cnt;

    // NOTE: registers take non-blocking (<=) assignments, so every flop samples
    // pre-edge values. This keeps the logic free of ordering races.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sc_regshift_serializer.sv
// -----------------------------------------------------------------------------
// sc_regshift_serializer
//   Parallel-in/serial-out transmit register.
//   A low pulse on the load strobe in IDLE captures a word. The word is then
//   shifted out MSB-first, one bit per shift tick. busy is high for the whole
//   transfer. done pulses for one cycle after the last bit.
// Ports
//   SC_RegSHIFT_CLOCK_50      system clock, rising edge
//   SC_RegSHIFT_RESET_InHigh  synchronous active-high reset
//   SC_RegSHIFT_load_InLow    active-low load strobe, sampled only in IDLE
//   SC_RegSHIFT_data_InBUS    parallel word to transmit
//   SC_RegSHIFT_shift_InHigh  shift tick, sampled only in SHIFT
//   SC_RegSHIFT_serial_Out    serial data, MSB first, idles low
//   SC_RegSHIFT_busy_Out      high in SHIFT and DONE
//   SC_RegSHIFT_done_Out      one-cycle completion pulse
//   SC_RegSHIFT_data_OutBUS   current shift-register contents
// -----------------------------------------------------------------------------
module sc_regshift_serializer
    import sc_regshift_pkg::*;
#(
    parameter int RegSHIFT_DATAWIDTH = 4,
    parameter int RegSHIFT_CNTWIDTH  = 2
) (
    input  logic                          SC_RegSHIFT_CLOCK_50,
    input  logic                          SC_RegSHIFT_RESET_InHigh,
    input  logic                          SC_RegSHIFT_load_InLow,
    input  logic [RegSHIFT_DATAWIDTH-1:0] SC_RegSHIFT_data_InBUS,
    input  logic                          SC_RegSHIFT_shift_InHigh,
    output logic                          SC_RegSHIFT_serial_Out,
    output logic                          SC_RegSHIFT_busy_Out,
    output logic                          SC_RegSHIFT_done_Out,
    output logic [RegSHIFT_DATAWIDTH-1:0] SC_RegSHIFT_data_OutBUS
);

    localparam int DW = RegSHIFT_DATAWIDTH;
    localparam logic [RegSHIFT_CNTWIDTH-1:0] CNT_START = RegSHIFT_CNTWIDTH'(DW - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [DW-1:0]   r_data;
    logic [DW-1:0]   w_data_next;
    logic            w_cnt_load;
    logic            w_cnt_dec;
    logic            w_cnt_zero;

    // ---------------- next-state / next-data logic ----------------
    // NOTE: every signal written here gets a default first. Without the
    // default, a path that skips an assignment would infer a latch.
    always_comb begin
        w_state_next = ST_IDLE;
        w_data_next  = r_data;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!SC_RegSHIFT_load_InLow) begin
                    w_data_next  = SC_RegSHIFT_data_InBUS;
                    w_cnt_load   = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_state_next = ST_SHIFT;
                if (SC_RegSHIFT_shift_InHigh) begin
                    w_data_next = {r_data[DW-2:0], 1'b0};
                    // The last bit leaves at count zero. The counter is not
                    // decremented there, so it cannot underflow.
                    if (w_cnt_zero) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge SC_RegSHIFT_CLOCK_50) begin
        if (SC_RegSHIFT_RESET_InHigh) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_data  <= w_data_next;
        end
    end

    sc_regshift_bitcounter #(
        .CNTWIDTH (RegSHIFT_CNTWIDTH)
    ) u_bitcounter (
        .i_clk      (SC_RegSHIFT_CLOCK_50),
        .i_rst      (SC_RegSHIFT_RESET_InHigh),
        .i_load     (w_cnt_load),
        .i_load_val (CNT_START),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // ---------------- output decode (registered state only) ----------------
    assign SC_RegSHIFT_serial_Out  = (r_state == ST_SHIFT) ? r_data[DW-1] : 1'b0;
    assign SC_RegSHIFT_busy_Out    = (r_state == ST_SHIFT) || (r_state == ST_DONE);
    assign SC_RegSHIFT_done_Out    = (r_state == ST_DONE);
    assign SC_RegSHIFT_data_OutBUS = r_data;

endmodule
